// File: rtl/gpio_in_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpio_in_conditioner: synchronise, debounce and edge-detect raw GPIO inputs.
// Optional sticky edge events/irq when GPIO_IN_EDGE_IRQ_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
module gpio_in_conditioner #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_MAX  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] ev_clr,
  output logic [WIDTH-1:0] event_q,
  output logic             irq
);

  localparam int CNT_W = ($clog2(DB_CNT_MAX + 1) < 1) ? 1 : $clog2(DB_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CNT_MAX);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] r_gpio, r_rise, r_fall;
  logic [WIDTH-1:0] w_s, w_gpio_next, w_rise_next, w_fall_next;

  // Pure flop chain: nothing may sit between synchroniser stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_gpio_next = r_gpio;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (w_s[i] != r_gpio[i]) begin
        if (r_cnt[i] == C_CNT_MAX) w_gpio_next[i] = w_s[i];
        else                       w_cnt_next[i]  = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise_next = w_gpio_next & ~r_gpio;
  assign w_fall_next = ~w_gpio_next & r_gpio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_gpio <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
      r_gpio <= w_gpio_next;
      r_rise <= w_rise_next;
      r_fall <= w_fall_next;
    end
  end

  assign gpio_in = r_gpio;
  assign rise    = r_rise;
  assign fall    = r_fall;

`ifdef GPIO_IN_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_event, w_event_next;
  logic             r_irq;

  // Set has priority over a same-edge clear so no event is ever lost.
  assign w_event_next = (r_event & ~ev_clr) | w_rise_next | w_fall_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_event <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_event <= w_event_next;
      r_irq   <= |w_event_next;
    end
  end

  assign event_q = r_event;
  assign irq     = r_irq;
`else
  logic w_unused_ev_clr;
  assign w_unused_ev_clr = ^ev_clr;
  assign event_q = '0;
  assign irq     = 1'b0;
`endif

endmodule
`default_nettype wire
